mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
// - Main-memory end of the common snoop bus: services BusRd/BusRdX line fills and Mem_wr write-backs issued by the L1 cache controllers.
// - Sits on Address_Com/Data_Bus_Com beside the arbiter.
// - Yields to a snooping cache that asserts Mem_oprn_abort.
// PARAMETERS
// - ADDR_WIDTH  32   Address_Com width.
// - DATA_WIDTH  32   Data_Bus_Com width.
// - MEM_DEPTH   256  words in backing store; index = Address_Com[$clog2(MEM_DEPTH)+1:2].
// - RD_LAT      4    wait cycles between read accept and data drive (>=1).
// - WR_LAT      2    wait cycles between write accept and array update (>=1).
// PORTS
// - clk             in     1           bus clock, all logic on posedge.
// - rst_n           in     1           asynchronous active-low reset.
// - Address_Com     in     ADDR_WIDTH  request address.
// - Data_Bus_Com    inout  DATA_WIDTH  shared data bus; driven only in RD_DRIVE, else 'z.
// - BusRd           in     1           read-miss fill request; held by requester until Data_in_Bus.
// - BusRdX          in     1           read-for-ownership fill request; same handshake as BusRd.
// - Mem_wr          in     1           write-back request; data on Data_Bus_Com; held until Mem_write_done.
// - Mem_oprn_abort  in     1           a snooper supplies the line; cancel the pending read.
// - Data_in_Bus     out    1           memory data valid on Data_Bus_Com.
// - Mem_write_done  out    1           write-back committed.
// BEHAVIOUR
// - Interface: one clock (clk); asynchronous active-low reset (rst_n).
// - Reset: state=IDLE, Data_in_Bus=0, Mem_write_done=0, bus released ('z), counter=0, all valid bits=0.
//   - Array contents are not reset.
//   - Reset mid-operation abandons the transfer; an uncommitted write is lost.
// - FSM: IDLE, RD_WAIT, RD_DRIVE, RD_ABORTED, WR_WAIT, WR_DONE.
// - IDLE
//   - Mem_wr=1: latch addr and data -> WR_WAIT, cnt=WR_LAT. Mem_wr has priority over BusRd/BusRdX in the same cycle.
//   - Else (BusRd|BusRdX)=1: latch addr -> RD_WAIT, cnt=RD_LAT.
// - RD_WAIT
//   - Mem_oprn_abort=1 -> RD_ABORTED. Abort wins over cnt reaching 0 in the same cycle.
//   - Else cnt--; on cnt==1 -> RD_DRIVE.
// - RD_DRIVE
//   - Drive mem[idx] (or fallback, see CONFIGURATION) on Data_Bus_Com and assert Data_in_Bus.
//   - First Data_in_Bus cycle is RD_LAT+1 cycles after the accept edge.
//   - Hold until BusRd=BusRdX=0, then release the bus and deassert on that edge -> IDLE.
// - RD_ABORTED
//   - Outputs stay 0.
//   - Mem_wr=1 -> accept the write-back (flush) as in IDLE.
//   - BusRd=BusRdX=0 -> IDLE.
//   - A still-held request is re-serviced from IDLE and returns the flushed data.
// - WR_WAIT
//   - cnt--; on cnt==1 write mem[idx], set valid[idx] -> WR_DONE.
//   - Mem_oprn_abort is ignored for writes.
// - WR_DONE
//   - Mem_write_done=1 until Mem_wr=0, then deassert -> IDLE.
// - Index arithmetic: bits above the index and the byte-offset bits [1:0] are ignored; addresses alias modulo MEM_DEPTH.
// - Latched addr/data are stable through the transaction; Address_Com changes after accept are ignored.
// CONFIGURATION
// - Macro MEM_ADDR_PATTERN_EN.
//   - Defined: a read of a word with valid=0 returns the full latched address (e.g. 32'hdeadbeef).
//   - Undefined: such a read returns 0.
//   - Either way, written words return stored data.
// STRUCTURE
// - Package mem_resp_pkg holds:
//   - typedef enum logic [2:0] mem_resp_state_t;
//   - default MEM_DEPTH/RD_LAT/WR_LAT localparams;
//   - function mem_idx().
// - Sub-module mem_store: array + valid bits.
//   - 1 write port, 1 async read port, and the MEM_ADDR_PATTERN_EN fallback mux.
// - Top holds the FSM, latency counter, and tristate driver.
// TESTING
// - Reset: rst_n=0 mid-RD_DRIVE -> Data_in_Bus=0, Mem_write_done=0, Data_Bus_Com='z immediately (async).
// - Write: Mem_wr, addr 32'hbabecafe, data 32'hcafecafe -> Mem_write_done rises WR_LAT+1 edges after accept; falls one edge after Mem_wr drops.
// - Read hit: BusRd addr 32'hbabecafe (after the write) -> Data_in_Bus=1 at RD_LAT+1 edges, bus=32'hcafecafe; released after BusRd drops.
// - Unwritten read: BusRdX addr 32'hdeadbeef -> 32'hdeadbeef with MEM_ADDR_PATTERN_EN, 32'h0 without.
// - Abort+flush: BusRd addr 32'h100, Mem_oprn_abort on wait cycle 2, then Mem_wr data 32'h1234_5678 with BusRd held
//   -> no Data_in_Bus during the abort; Mem_write_done; then re-read returns 32'h1234_5678.
// - Collision: Mem_wr and BusRdX to the same address in the same cycle -> write commits first; read returns the written data.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types, default sizing and index helper for the memory bus responder.
package mem_resp_pkg;

  localparam int unsigned DEF_MEM_DEPTH = 256;
  localparam int unsigned DEF_RD_LAT    = 4;
  localparam int unsigned DEF_WR_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    RD_ABORTED,
    WR_WAIT,
    WR_DONE
  } mem_resp_state_t;

  // Word index of a byte address: drop the byte offset, wrap modulo depth (power of two).
  function automatic logic [31:0] mem_idx(input logic [63:0] addr, input int unsigned depth);
    logic [63:0] word;
    word = addr >> 2;
    return 32'(word & 64'(depth - 1));
  endfunction

endpackage

// File: rtl/mem_store.sv
// Backing store for the memory responder: word array plus per-word valid bits.
// One synchronous write port, one asynchronous read port.
// Unwritten words read as 0, or as the request address when MEM_ADDR_PATTERN_EN is defined.
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears valid bits only)
//   wr_en       - write wr_data into wr_idx on posedge
//   wr_idx      - write word index
//   wr_data     - write data
//   rd_idx      - read word index
//   rd_addr     - full request address, used as the fallback pattern
//   rd_data_c   - combinational read data
module mem_store
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_MEM_DEPTH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

`ifdef MEM_ADDR_PATTERN_EN
  always_comb begin
    rd_data_c = valid_q[rd_idx] ? mem[rd_idx] : DATA_WIDTH'(rd_addr);
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;

  always_comb begin
    rd_data_c = valid_q[rd_idx] ? mem[rd_idx] : '0;
  end
`endif

endmodule

// File: rtl/mem_bus_responder.sv
// Main-memory responder on the shared snoop bus: services BusRd/BusRdX line
// fills and Mem_wr write-backs, and yields a pending read to Mem_oprn_abort.
// Optional macro MEM_ADDR_PATTERN_EN: unwritten words read back as their address.
// Ports:
//   clk, rst_n      - bus clock, async active-low reset
//   Address_Com     - request address (latched on accept)
//   Data_Bus_Com    - shared data bus; driven only while returning read data
//   BusRd, BusRdX   - fill requests, held until Data_in_Bus
//   Mem_wr          - write-back request, data on Data_Bus_Com, held until Mem_write_done
//   Mem_oprn_abort  - a snooper supplies the line; cancel the pending read
//   Data_in_Bus     - read data valid on Data_Bus_Com
//   Mem_write_done  - write-back committed
module mem_bus_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned RD_LAT     = DEF_RD_LAT,
  parameter int unsigned WR_LAT     = DEF_WR_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Address_Com,
  inout  wire  [DATA_WIDTH-1:0] Data_Bus_Com,
  input  logic                  BusRd,
  input  logic                  BusRdX,
  input  logic                  Mem_wr,
  input  logic                  Mem_oprn_abort,
  output logic                  Data_in_Bus,
  output logic                  Mem_write_done
);

  localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  mem_resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  drive_q, drive_d;
  logic                  data_in_bus_d;
  logic                  write_done_d;
  logic                  mem_we_c;
  logic                  rd_req_c;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] mem_rd_data_c;

  assign rd_req_c = BusRd | BusRdX;
  assign idx_c    = IDX_W'(mem_idx(64'(addr_q), MEM_DEPTH));

  mem_store #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (mem_we_c),
    .wr_idx    (idx_c),
    .wr_data   (wdata_q),
    .rd_idx    (idx_c),
    .rd_addr   (addr_q),
    .rd_data_c (mem_rd_data_c)
  );

  // Bus released unless returning read data.
  assign Data_Bus_Com = drive_q ? rd_data_q : {DATA_WIDTH{1'bz}};

  // State, latency counter, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_data_q      <= '0;
      drive_q        <= 1'b0;
      Data_in_Bus    <= 1'b0;
      Mem_write_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_data_q      <= rd_data_d;
      drive_q        <= drive_d;
      Data_in_Bus    <= data_in_bus_d;
      Mem_write_done <= write_done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_data_d     = rd_data_q;
    drive_d       = 1'b0;
    data_in_bus_d = 1'b0;
    write_done_d  = 1'b0;
    mem_we_c      = 1'b0;

    case (state_q)
      IDLE: begin
        // Write-back wins over a simultaneous fill request.
        if (Mem_wr) begin
          addr_d  = Address_Com;
          wdata_d = Data_Bus_Com;
          cnt_d   = CNT_W'(WR_LAT);
          state_d = WR_WAIT;
        end else if (rd_req_c) begin
          addr_d  = Address_Com;
          cnt_d   = CNT_W'(RD_LAT);
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // Abort takes precedence over the counter expiring.
        if (Mem_oprn_abort) begin
          state_d = RD_ABORTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = RD_DRIVE;
          end
        end
      end

      RD_DRIVE: begin
        if (rd_req_c) begin
          drive_d       = 1'b1;
          data_in_bus_d = 1'b1;
          rd_data_d     = mem_rd_data_c;
        end else begin
          state_d = IDLE;
        end
      end

      RD_ABORTED: begin
        // The snooper's flush is accepted here; a still-held read restarts from IDLE.
        if (Mem_wr) begin
          addr_d  = Address_Com;
          wdata_d = Data_Bus_Com;
          cnt_d   = CNT_W'(WR_LAT);
          state_d = WR_WAIT;
        end else if (!rd_req_c) begin
          state_d = IDLE;
        end
      end

      WR_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          mem_we_c = 1'b1;
          state_d  = WR_DONE;
        end
      end

      WR_DONE: begin
        if (Mem_wr) begin
          write_done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder (default parameters).
module tb_mem_bus_responder;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int          MAX_WAIT = 40;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] Address_Com;
  wire  [DW-1:0] Data_Bus_Com;
  logic          BusRd;
  logic          BusRdX;
  logic          Mem_wr;
  logic          Mem_oprn_abort;
  logic          Data_in_Bus;
  logic          Mem_write_done;

  logic          tb_drive;
  logic [DW-1:0] tb_data;

  int n_checks;
  int n_pass;
  bit saw_rd;

  assign Data_Bus_Com = tb_drive ? tb_data : {DW{1'bz}};

  mem_bus_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Address_Com    (Address_Com),
    .Data_Bus_Com   (Data_Bus_Com),
    .BusRd          (BusRd),
    .BusRdX         (BusRdX),
    .Mem_wr         (Mem_wr),
    .Mem_oprn_abort (Mem_oprn_abort),
    .Data_in_Bus    (Data_in_Bus),
    .Mem_write_done (Mem_write_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A released bus reads as z (4-state) or 0 (2-state).
  function automatic logic [31:0] bus_released();
    return 32'((Data_Bus_Com === {DW{1'bz}}) || (Data_Bus_Com === {DW{1'b0}}));
  endfunction

  // Count edges (accept edge = 1) until the flag rises; optionally check latency and read data.
  task automatic wait_rise(input string tag, input bit is_rd, input int exp_edges,
                           input logic [31:0] exp_data);
    int n;
    n = 0;
    while (!(is_rd ? Data_in_Bus : Mem_write_done) && n < MAX_WAIT) begin
      tick();
      n++;
      if (!is_rd && Data_in_Bus) saw_rd = 1'b1;
    end
    if (exp_edges != 0) check({tag, "_lat"}, 32'(n), 32'(exp_edges));
    else                check({tag, "_seen"}, 32'(n < MAX_WAIT), 32'd1);
    if (is_rd) check({tag, "_data"}, Data_Bus_Com, exp_data);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    saw_rd         = 1'b0;
    rst_n          = 1'b0;
    Address_Com    = '0;
    BusRd          = 1'b0;
    BusRdX         = 1'b0;
    Mem_wr         = 1'b0;
    Mem_oprn_abort = 1'b0;
    tb_drive       = 1'b0;
    tb_data        = '0;

    // Reset state
    tick();
    tick();
    check("rst_dib", 32'(Data_in_Bus), 32'd0);
    check("rst_wd", 32'(Mem_write_done), 32'd0);
    check("rst_bus", bus_released(), 32'd1);
    rst_n = 1'b1;
    tick();

    // Write-back: done at WR_LAT+1 edges after accept (accept counts as edge 1 -> 4)
    Address_Com = 32'hbabecafe;
    Mem_wr      = 1'b1;
    tb_drive    = 1'b1;
    tb_data     = 32'hcafecafe;
    wait_rise("wr", 1'b0, 4, 32'h0);
    tick();
    check("wr_hold", 32'(Mem_write_done), 32'd1);
    Mem_wr   = 1'b0;
    tb_drive = 1'b0;
    tick();
    check("wr_fall", 32'(Mem_write_done), 32'd0);

    // Read hit: data at RD_LAT+1 edges after accept (-> 6); address change after accept ignored
    Address_Com = 32'hbabecafe;
    BusRd       = 1'b1;
    tick();
    Address_Com = 32'h0;
    wait_rise("rdhit", 1'b1, 5, 32'hcafecafe);
    tick();
    check("rdhit_hold", 32'(Data_in_Bus), 32'd1);
    BusRd = 1'b0;
    tick();
    check("rdhit_rel_dib", 32'(Data_in_Bus), 32'd0);
    check("rdhit_rel_bus", bus_released(), 32'd1);

    // Unwritten word
    Address_Com = 32'hdeadbeef;
    BusRdX      = 1'b1;
`ifdef MEM_ADDR_PATTERN_EN
    wait_rise("unwr", 1'b1, 6, 32'hdeadbeef);
`else
    wait_rise("unwr", 1'b1, 6, 32'h0);
`endif
    BusRdX = 1'b0;
    tick();
    check("unwr_rel", 32'(Data_in_Bus), 32'd0);

    // Abort on wait cycle 2, then flush write with the read still held
    saw_rd      = 1'b0;
    Address_Com = 32'h100;
    BusRd       = 1'b1;
    tick();
    tick();
    Mem_oprn_abort = 1'b1;
    tick();
    Mem_oprn_abort = 1'b0;
    tick();
    tick();
    check("abort_dib", 32'(Data_in_Bus), 32'd0);
    Mem_wr   = 1'b1;
    tb_drive = 1'b1;
    tb_data  = 32'h1234_5678;
    wait_rise("flush", 1'b0, 4, 32'h0);
    check("flush_no_rd", 32'(saw_rd), 32'd0);
    Mem_wr   = 1'b0;
    tb_drive = 1'b0;
    // edge1 WR_DONE->IDLE, edge2 accept, data 5 edges later
    wait_rise("reread", 1'b1, 7, 32'h1234_5678);
    BusRd = 1'b0;
    tick();
    check("reread_rel", bus_released(), 32'd1);

    // Aliasing: high bits and byte offset ignored (0x503 -> same word as 0x100)
    Address_Com = 32'h0000_0503;
    BusRd       = 1'b1;
    wait_rise("alias", 1'b1, 6, 32'h1234_5678);
    BusRd = 1'b0;
    tick();

    // Collision: write and read-for-ownership together; write commits first
    saw_rd      = 1'b0;
    Address_Com = 32'h2c0;
    Mem_wr      = 1'b1;
    BusRdX      = 1'b1;
    tb_drive    = 1'b1;
    tb_data     = 32'ha5a5_0f0f;
    wait_rise("coll_wr", 1'b0, 4, 32'h0);
    check("coll_no_rd", 32'(saw_rd), 32'd0);
    Mem_wr   = 1'b0;
    tb_drive = 1'b0;
    wait_rise("coll_rd", 1'b1, 7, 32'ha5a5_0f0f);
    BusRdX = 1'b0;
    tick();

    // Asynchronous reset in the middle of a data drive
    Address_Com = 32'hbabecafe;
    BusRd       = 1'b1;
    wait_rise("pre_rst", 1'b1, 6, 32'hcafecafe);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_dib", 32'(Data_in_Bus), 32'd0);
    check("arst_wd", 32'(Mem_write_done), 32'd0);
    check("arst_bus", bus_released(), 32'd1);
    BusRd = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_dib", 32'(Data_in_Bus), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
